cordic_scheduler: RTL and testbench

Shares one `cordic_pipeline` instance among `NUM_REQ` requesters, one new operation per cycle. It arbitrates round-robin, registers the winning operand triple into the pipeline inputs and tracks each issued operation's requester ID alongside the datapath. It returns each result, tagged with that ID, on a single registered result port. A drain input stops new grants so software can quiesce the pipeline.

---
 rtl/cordic_sched_pkg.sv | 17 +
 rtl/cordic_pipeline.sv | 73 +++++++
 rtl/rr_arbiter.sv | 35 +++
 rtl/cordic_scheduler.sv | 131 +++++++++++++
 tb/tb_cordic_scheduler.sv | 435 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/cordic_sched_pkg.sv
// Shared types and helpers for the CORDIC scheduler slice.
// Defines the word width, the FSM encoding and the ID-width helper.
package cordic_sched_pkg;

    localparam int W = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    function automatic int id_width(int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/cordic_pipeline.sv
// Unrolled CORDIC rotation datapath, one register stage per iteration.
// Sits behind cordic_scheduler; instantiated by the parent.
module cordic_pipeline #(
    parameter int M = 6,
    parameter int N = 10,
    parameter int ITER = 11,
    localparam int WD = M + N
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [WD-1:0] x0,
    input  logic [WD-1:0] y0,
    input  logic [WD-1:0] z0,
    output logic [WD-1:0] xo,
    output logic [WD-1:0] yo,
    output logic [WD-1:0] zo
);

    // atan(2^-i) with 16 fraction bits, rounded to N bits on use
    localparam int ATAN16 [16] = '{
        51472, 30386, 16055, 8150, 4091, 2047, 1024, 512,
        256, 128, 64, 32, 16, 8, 4, 2
    };

    function automatic logic signed [WD-1:0] atan_n(int i);
        return WD'((ATAN16[i] + (1 << (15 - N))) >> (16 - N));
    endfunction

    logic signed [WD-1:0] xi [ITER];
    logic signed [WD-1:0] yi [ITER];
    logic signed [WD-1:0] zi [ITER];
    logic signed [WD-1:0] xs [ITER];
    logic signed [WD-1:0] ys [ITER];
    logic signed [WD-1:0] zs [ITER];

    always_comb begin
        xi[0] = x0;
        yi[0] = y0;
        zi[0] = z0;
        for (int i = 1; i < ITER; i++) begin
            xi[i] = xs[i-1];
            yi[i] = ys[i-1];
            zi[i] = zs[i-1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < ITER; i++) begin
                xs[i] <= '0;
                ys[i] <= '0;
                zs[i] <= '0;
            end
        end else begin
            for (int i = 0; i < ITER; i++) begin
                if (zi[i][WD-1]) begin
                    xs[i] <= xi[i] + (yi[i] >>> i);
                    ys[i] <= yi[i] - (xi[i] >>> i);
                    zs[i] <= zi[i] + atan_n(i);
                end else begin
                    xs[i] <= xi[i] - (yi[i] >>> i);
                    ys[i] <= yi[i] + (xi[i] >>> i);
                    zs[i] <= zi[i] - atan_n(i);
                end
            end
        end
    end

    assign xo = xs[ITER-1];
    assign yo = ys[ITER-1];
    assign zo = zs[ITER-1];

endmodule

// File: rtl/rr_arbiter.sv
// Rotating-priority arbiter: first requester at or above ptr wins.
module rr_arbiter
    import cordic_sched_pkg::*;
#(
    parameter int NUM_REQ = 4,
    localparam int IW = id_width(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IW-1:0]      ptr,
    input  logic               enable,
    output logic [NUM_REQ-1:0] gnt
);

    logic hit;

    always_comb begin
        gnt = '0;
        hit = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!hit && req[i] && i >= int'(ptr)) begin
                gnt[i] = 1'b1;
                hit = 1'b1;
            end
        end
        // wrap-around pass for requesters below the pointer
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!hit && req[i] && i < int'(ptr)) begin
                gnt[i] = 1'b1;
                hit = 1'b1;
            end
        end
        if (!enable) gnt = '0;
    end

endmodule

// File: rtl/cordic_scheduler.sv
// Shares one CORDIC pipeline among NUM_REQ requesters.
// Tags each issued op with its requester ID and returns tagged results.
module cordic_scheduler
    import cordic_sched_pkg::*;
#(
    parameter int M = 6,
    parameter int N = 10,
    parameter int NUM_REQ = 4,
    parameter int PIPE_LAT = 11,
    localparam int WD = M + N,
    localparam int IW = id_width(NUM_REQ),
    localparam int CW = $clog2(PIPE_LAT + 2)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NUM_REQ-1:0]    req_valid,
    output logic [NUM_REQ-1:0]    req_ready,
    input  logic [NUM_REQ*WD-1:0] req_x,
    input  logic [NUM_REQ*WD-1:0] req_y,
    input  logic [NUM_REQ*WD-1:0] req_z,
    input  logic                  drain,
    output logic                  busy,
    output logic [WD-1:0]         pipe_x0,
    output logic [WD-1:0]         pipe_y0,
    output logic [WD-1:0]         pipe_z0,
    input  logic [WD-1:0]         pipe_out_x,
    input  logic [WD-1:0]         pipe_out_y,
    input  logic [WD-1:0]         pipe_out_z,
    output logic                  res_valid,
    output logic [IW-1:0]         res_id,
    output logic [WD-1:0]         res_x,
    output logic [WD-1:0]         res_y,
    output logic [WD-1:0]         res_z
);

    typedef struct packed {
        logic          valid;
        logic [IW-1:0] id;
    } tag_t;

    state_t        state, state_nxt;
    logic [IW-1:0] rr_ptr, gid;
    logic [CW-1:0] cnt, cnt_nxt;
    tag_t          tag [PIPE_LAT+1];
    logic          issue, retire;

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
        .req    (req_valid),
        .ptr    (rr_ptr),
        .enable (~drain),
        .gnt    (req_ready)
    );

    assign issue  = |(req_valid & req_ready);
    assign retire = tag[PIPE_LAT].valid;
    assign busy   = (cnt != '0);

    always_comb begin
        gid = '0;
        for (int i = 0; i < NUM_REQ; i++)
            if (req_ready[i]) gid = IW'(i);
    end

    always_comb begin
        cnt_nxt = cnt;
        if (issue && !retire)      cnt_nxt = cnt + 1'b1;
        else if (!issue && retire) cnt_nxt = cnt - 1'b1;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (drain && cnt_nxt != '0) state_nxt = DRAIN;
                else if (issue)             state_nxt = RUN;
            end
            RUN: begin
                if (cnt_nxt == '0) state_nxt = IDLE;
                else if (drain)    state_nxt = DRAIN;
            end
            DRAIN: begin
                if (cnt_nxt == '0) state_nxt = IDLE;
                else if (!drain)   state_nxt = RUN;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            rr_ptr  <= '0;
            cnt     <= '0;
            pipe_x0 <= '0;
            pipe_y0 <= '0;
            pipe_z0 <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (issue) begin
                rr_ptr  <= (int'(gid) == NUM_REQ - 1) ? '0 : gid + 1'b1;
                pipe_x0 <= req_x[gid*WD +: WD];
                pipe_y0 <= req_y[gid*WD +: WD];
                pipe_z0 <= req_z[gid*WD +: WD];
            end
        end
    end

    // tag[PIPE_LAT] lines up with the pipeline output word
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k <= PIPE_LAT; k++) tag[k] <= '0;
            res_valid <= 1'b0;
            res_id    <= '0;
            res_x     <= '0;
            res_y     <= '0;
            res_z     <= '0;
        end else begin
            tag[0] <= issue ? tag_t'{valid: 1'b1, id: gid} : '0;
            for (int k = 1; k <= PIPE_LAT; k++) tag[k] <= tag[k-1];
            res_valid <= retire;
            res_id    <= tag[PIPE_LAT].id;
            if (retire) begin
                res_x <= pipe_out_x;
                res_y <= pipe_out_y;
                res_z <= pipe_out_z;
            end
        end
    end

endmodule

// File: tb/tb_cordic_scheduler.sv
// Directed bench: scheduler driving the real CORDIC pipeline.
module tb_cordic_scheduler;
    import cordic_sched_pkg::*;

    localparam int NR  = 4;
    localparam int LAT = 11;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [NR-1:0]     req_valid;
    logic [NR-1:0]     req_ready;
    logic [NR*W-1:0]   req_x, req_y, req_z;
    logic              drain;
    logic              busy;
    logic [W-1:0]      pipe_x0, pipe_y0, pipe_z0;
    logic [W-1:0]      pipe_out_x, pipe_out_y, pipe_out_z;
    logic              res_valid;
    logic [1:0]        res_id;
    logic [W-1:0]      res_x, res_y, res_z;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    cordic_scheduler #(.M(6), .N(10), .NUM_REQ(NR), .PIPE_LAT(LAT)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_x      (req_x),
        .req_y      (req_y),
        .req_z      (req_z),
        .drain      (drain),
        .busy       (busy),
        .pipe_x0    (pipe_x0),
        .pipe_y0    (pipe_y0),
        .pipe_z0    (pipe_z0),
        .pipe_out_x (pipe_out_x),
        .pipe_out_y (pipe_out_y),
        .pipe_out_z (pipe_out_z),
        .res_valid  (res_valid),
        .res_id     (res_id),
        .res_x      (res_x),
        .res_y      (res_y),
        .res_z      (res_z)
    );

    cordic_pipeline #(.M(6), .N(10), .ITER(LAT)) u_pipe (
        .clk   (clk),
        .rst_n (rst_n),
        .x0    (pipe_x0),
        .y0    (pipe_y0),
        .z0    (pipe_z0),
        .xo    (pipe_out_x),
        .yo    (pipe_out_y),
        .zo    (pipe_out_z)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ops(int i, logic [W-1:0] x, logic [W-1:0] y, logic [W-1:0] z);
        req_x[i*W +: W] = x;
        req_y[i*W +: W] = y;
        req_z[i*W +: W] = z;
    endtask

    task automatic do_reset();
        req_valid = '0;
        drain = 1'b0;
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b1;
        req_valid = '0;
        drain = 1'b0;
        req_x = '0;
        req_y = '0;
        req_z = '0;
        #2 rst_n = 1'b0;
        step();
        checks++;
        if ({res_valid, res_id, res_x, res_y, res_z} !== '0) begin
            errors++;
            $display("FAIL reset_res: got %b/%0h/%0h/%0h/%0h expected all 0",
                     res_valid, res_id, res_x, res_y, res_z);
        end
        checks++;
        if ({pipe_x0, pipe_y0, pipe_z0} !== '0) begin
            errors++;
            $display("FAIL reset_pipe: got %0h/%0h/%0h expected 0", pipe_x0, pipe_y0, pipe_z0);
        end
        checks++;
        if (busy !== 1'b0 || dut.cnt !== '0) begin
            errors++;
            $display("FAIL reset_busy: got busy=%b cnt=%0d expected 0/0", busy, dut.cnt);
        end
        checks++;
        if (dut.state !== IDLE || dut.rr_ptr !== 2'd0) begin
            errors++;
            $display("FAIL reset_state: got state=%0d ptr=%0d expected 0/0", dut.state, dut.rr_ptr);
        end
        req_valid = 4'b0100;
        #1;
        checks++;
        if (req_ready !== 4'b0100) begin
            errors++;
            $display("FAIL reset_ready: got %b expected 0100", req_ready);
        end
        req_valid = 4'b0110;
        #1;
        checks++;
        if (req_ready !== 4'b0010) begin
            errors++;
            $display("FAIL reset_ready_prio: got %b expected 0010", req_ready);
        end
        drain = 1'b1;
        #1;
        checks++;
        if (req_ready !== 4'b0000) begin
            errors++;
            $display("FAIL reset_drain_block: got %b expected 0000", req_ready);
        end
        req_valid = '0;
        drain = 1'b0;
        step();
        rst_n = 1'b1;
    endtask

    task automatic test_single_op();
        int lat;
        logic seen;
        int d;
        set_ops(2, 16'h026E, 16'h0000, 16'h0324);
        req_valid = 4'b0100;
        #1;
        checks++;
        if (req_ready !== 4'b0100) begin
            errors++;
            $display("FAIL single_ready: got %b expected 0100", req_ready);
        end
        step();
        req_valid = '0;
        checks++;
        if ({pipe_x0, pipe_y0, pipe_z0} !== {16'h026E, 16'h0000, 16'h0324}) begin
            errors++;
            $display("FAIL single_issue: got %0h/%0h/%0h expected 26e/0/324", pipe_x0, pipe_y0, pipe_z0);
        end
        checks++;
        if (dut.rr_ptr !== 2'd3 || dut.state !== RUN || dut.cnt !== 4'd1) begin
            errors++;
            $display("FAIL single_state: got ptr=%0d st=%0d cnt=%0d expected 3/1/1",
                     dut.rr_ptr, dut.state, dut.cnt);
        end
        lat = 0;
        seen = 1'b0;
        for (int k = 1; k <= 20 && !seen; k++) begin
            step();
            if (res_valid) begin
                seen = 1'b1;
                lat = k;
            end
        end
        checks++;
        if (lat != 12) begin
            errors++;
            $display("FAIL single_latency: got %0d expected 12", lat);
        end
        checks++;
        if (res_id !== 2'd2) begin
            errors++;
            $display("FAIL single_id: got %0d expected 2", res_id);
        end
        d = int'(res_x) - 724;
        checks++;
        if (d < -4 || d > 4) begin
            errors++;
            $display("FAIL single_x: got %0h expected 2d4 +-4", res_x);
        end
        d = int'(res_y) - 724;
        checks++;
        if (d < -4 || d > 4) begin
            errors++;
            $display("FAIL single_y: got %0h expected 2d4 +-4", res_y);
        end
        step();
        checks++;
        if (res_valid !== 1'b0 || busy !== 1'b0 || dut.state !== IDLE) begin
            errors++;
            $display("FAIL single_after: got v=%b busy=%b st=%0d expected 0/0/0",
                     res_valid, busy, dut.state);
        end
    endtask

    task automatic test_fairness();
        logic exp_v;
        logic exp_b;
        do_reset();
        for (int i = 0; i < NR; i++)
            set_ops(i, W'(16'h0100 + i), W'(16'h0010 * i), 16'h0000);
        req_valid = '1;
        for (int k = 0; k < 8; k++) begin
            #1;
            checks++;
            if (req_ready !== 4'(1 << (k % 4))) begin
                errors++;
                $display("FAIL fair_grant%0d: got %b expected %b", k, req_ready, 4'(1 << (k % 4)));
            end
            step();
            if (k == 7) req_valid = '0;
            checks++;
            if (pipe_x0 !== W'(16'h0100 + (k % 4)) || busy !== 1'b1) begin
                errors++;
                $display("FAIL fair_issue%0d: got x0=%0h busy=%b expected %0h/1",
                         k, pipe_x0, busy, 16'h0100 + (k % 4));
            end
        end
        for (int e = 9; e <= 22; e++) begin
            step();
            exp_v = (e >= 13 && e <= 20);
            exp_b = (e < 20);
            checks++;
            if (res_valid !== exp_v || (exp_v && res_id !== 2'((e - 13) % 4))) begin
                errors++;
                $display("FAIL fair_result_e%0d: got v=%b id=%0d expected v=%b id=%0d",
                         e, res_valid, res_id, exp_v, (e - 13) % 4);
            end
            checks++;
            if (busy !== exp_b) begin
                errors++;
                $display("FAIL fair_busy_e%0d: got %b expected %b", e, busy, exp_b);
            end
        end
    endtask

    task automatic test_drain();
        logic exp_v;
        do_reset();
        set_ops(0, 16'h0200, 16'h0000, 16'h0000);
        req_valid = 4'b0001;
        step();
        step();
        step();
        drain = 1'b1;
        #1;
        checks++;
        if (req_ready !== 4'b0000) begin
            errors++;
            $display("FAIL drain_ready: got %b expected 0000", req_ready);
        end
        step();
        checks++;
        if (dut.state !== DRAIN || dut.cnt !== 4'd3) begin
            errors++;
            $display("FAIL drain_state: got st=%0d cnt=%0d expected 2/3", dut.state, dut.cnt);
        end
        for (int e = 5; e <= 16; e++) begin
            step();
            exp_v = (e >= 13 && e <= 15);
            checks++;
            if (res_valid !== exp_v || (exp_v && res_id !== 2'd0)) begin
                errors++;
                $display("FAIL drain_result_e%0d: got v=%b id=%0d expected v=%b id=0",
                         e, res_valid, res_id, exp_v);
            end
            if (e == 14) begin
                checks++;
                if (busy !== 1'b1) begin
                    errors++;
                    $display("FAIL drain_busy_hi: got %b expected 1", busy);
                end
            end
        end
        checks++;
        if (busy !== 1'b0 || dut.state !== IDLE || req_ready !== 4'b0000) begin
            errors++;
            $display("FAIL drain_end: got busy=%b st=%0d rdy=%b expected 0/0/0000",
                     busy, dut.state, req_ready);
        end
        drain = 1'b0;
        #1;
        checks++;
        if (req_ready !== 4'b0001) begin
            errors++;
            $display("FAIL drain_release: got %b expected 0001", req_ready);
        end
        req_valid = '0;
    endtask

    task automatic test_full_pipe();
        int exp_c;
        logic exp_v;
        do_reset();
        set_ops(1, 16'h0100, 16'h0000, 16'h0000);
        req_valid = 4'b0010;
        for (int k = 1; k <= 20; k++) begin
            step();
            exp_c = (k < 12) ? k : 12;
            exp_v = (k >= 13);
            checks++;
            if (int'(dut.cnt) != exp_c) begin
                errors++;
                $display("FAIL full_cnt_k%0d: got %0d expected %0d", k, dut.cnt, exp_c);
            end
            checks++;
            if (res_valid !== exp_v || (exp_v && res_id !== 2'd1)) begin
                errors++;
                $display("FAIL full_res_k%0d: got v=%b id=%0d expected v=%b id=1",
                         k, res_valid, res_id, exp_v);
            end
        end
        req_valid = '0;
        repeat (12) step();
        checks++;
        if (dut.cnt !== '0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL full_empty: got cnt=%0d busy=%b expected 0/0", dut.cnt, busy);
        end
    endtask

    task automatic test_reset_midflight();
        logic seen;
        do_reset();
        for (int i = 0; i < NR; i++)
            set_ops(i, W'(16'h0040 * (i + 1)), 16'h0000, 16'h0000);
        req_valid = '1;
        repeat (4) step();
        req_valid = '0;
        repeat (5) step();
        checks++;
        if (busy !== 1'b1 || dut.cnt !== 4'd4) begin
            errors++;
            $display("FAIL mid_before: got busy=%b cnt=%0d expected 1/4", busy, dut.cnt);
        end
        rst_n = 1'b0;
        #2;
        checks++;
        if ({res_valid, res_id, res_x, res_y, res_z, pipe_x0, pipe_y0, pipe_z0, busy} !== '0) begin
            errors++;
            $display("FAIL mid_outputs: got v=%b id=%0d x0=%0h busy=%b expected all 0",
                     res_valid, res_id, pipe_x0, busy);
        end
        checks++;
        if (dut.rr_ptr !== 2'd0 || dut.cnt !== '0 || dut.state !== IDLE) begin
            errors++;
            $display("FAIL mid_regs: got ptr=%0d cnt=%0d st=%0d expected 0/0/0",
                     dut.rr_ptr, dut.cnt, dut.state);
        end
        step();
        rst_n = 1'b1;
        seen = 1'b0;
        for (int k = 0; k < 20; k++) begin
            step();
            if (res_valid) seen = 1'b1;
        end
        checks++;
        if (seen !== 1'b0) begin
            errors++;
            $display("FAIL mid_no_result: got res_valid seen=%b expected 0", seen);
        end
    endtask

    task automatic test_sparse();
        int nres;
        do_reset();
        set_ops(0, 16'h0011, 16'h0000, 16'h0000);
        set_ops(3, 16'h0033, 16'h0000, 16'h0000);
        req_valid = 4'b0001;
        #1;
        checks++;
        if (req_ready !== 4'b0001) begin
            errors++;
            $display("FAIL sparse_g0: got %b expected 0001", req_ready);
        end
        step();
        req_valid = 4'b1000;
        #1;
        checks++;
        if (req_ready !== 4'b1000 || dut.rr_ptr !== 2'd1) begin
            errors++;
            $display("FAIL sparse_g3: got rdy=%b ptr=%0d expected 1000/1", req_ready, dut.rr_ptr);
        end
        step();
        req_valid = '0;
        checks++;
        if (dut.rr_ptr !== 2'd0 || pipe_x0 !== 16'h0033) begin
            errors++;
            $display("FAIL sparse_ptr: got ptr=%0d x0=%0h expected 0/33", dut.rr_ptr, pipe_x0);
        end
        nres = 0;
        for (int e = 3; e <= 16; e++) begin
            step();
            if (res_valid) nres++;
            if (e == 13 || e == 14) begin
                checks++;
                if (res_valid !== 1'b1 || res_id !== ((e == 13) ? 2'd0 : 2'd3)) begin
                    errors++;
                    $display("FAIL sparse_res_e%0d: got v=%b id=%0d expected 1/%0d",
                             e, res_valid, res_id, (e == 13) ? 0 : 3);
                end
            end
        end
        checks++;
        if (nres != 2) begin
            errors++;
            $display("FAIL sparse_count: got %0d expected 2", nres);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_single_op();
        test_fairness();
        test_drain();
        test_full_pipe();
        test_reset_midflight();
        test_sparse();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
